pw_tile_scheduler: RTL

Sequencer that drives one conv_unit through a pointwise (PW) tile: weight load, then repeated ifmap/ipsum/opsum passes that reuse the loaded weights. It generates GLB read and write addresses, moves GLB read data onto the conv_unit data_in bus under valid/ready, and writes conv_unit opsum words back to GLB. It sits between the GLB and conv_unit and is started by the layer controller.

---
 rtl/pw_tile_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pw_tile_scheduler.sv
// Pointwise tile sequencer: weight load once, then per-pass ifmap/ipsum loads and opsum stores between GLB and conv_unit.
// Reads land 1 cycle after issue into a 2-deep skid, so 1 word/cycle streams; ready low freezes cu_data_in and valid.
module pw_tile_scheduler #(
    parameter int ADDR_W = 16,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        cfg_row_en,
    input  logic [5:0]        cfg_col_en,
    input  logic [PASS_W-1:0] cfg_num_pass,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_if_base,
    input  logic [ADDR_W-1:0] cfg_ip_base,
    input  logic [ADDR_W-1:0] cfg_op_base,
    output logic              busy,
    output logic              done,
    output logic              glb_rd_en,
    output logic [ADDR_W-1:0] glb_rd_addr,
    input  logic [31:0]       glb_rd_data,
    output logic              glb_wr_en,
    output logic [ADDR_W-1:0] glb_wr_addr,
    output logic [31:0]       glb_wr_data,
    output logic [31:0]       cu_data_in,
    input  logic [31:0]       cu_data_out,
    output logic              cu_valid_w,
    output logic              cu_valid_if,
    output logic              cu_valid_ip,
    input  logic              cu_ready_w,
    input  logic              cu_ready_if,
    input  logic              cu_ready_ip,
    input  logic              cu_valid_op,
    output logic              cu_ready_op,
    output logic              cu_dw_pw_sel,
    output logic              cu_change_weight_f,
    output logic [5:0]        cu_row_en,
    output logic [5:0]        cu_col_en
);

    typedef enum logic [2:0] {IDLE, LD_W, LD_IF, LD_IP, ST_OP, FIN} state_t;

    state_t            state;
    logic [5:0]        row_q, col_q;
    logic [PASS_W-1:0] npass_q, pass_q;
    logic [ADDR_W-1:0] w_base_q, if_addr_q, ip_addr_q, op_addr_q;
    logic [8:0]        issued_cnt, acc_cnt, op_cnt;
    logic              rd_pend;
    logic [1:0]        sk_cnt;
    logic [31:0]       sk0, sk1;

    logic [8:0]        nw, ni, np, n_cur;
    logic [ADDR_W-1:0] base_cur;
    logic              load_st, rdy_cur, accept, last_acc, op_acc, last_op;
    logic [1:0]        occ;

    assign cu_dw_pw_sel = 1'b1;
    assign cu_row_en    = row_q;
    assign cu_col_en    = col_q;

    always_comb begin
        nw       = 9'(row_q) * 9'((7'(col_q) + 7'd3) >> 2);
        ni       = {3'd0, col_q};
        np       = {2'd0, row_q, 1'b0};
        load_st  = (state == LD_W) || (state == LD_IF) || (state == LD_IP);
        n_cur    = nw;
        base_cur = w_base_q;
        rdy_cur  = cu_ready_w;
        case (state)
            LD_IF: begin
                n_cur    = ni;
                base_cur = if_addr_q;
                rdy_cur  = cu_ready_if;
            end
            LD_IP: begin
                n_cur    = np;
                base_cur = ip_addr_q;
                rdy_cur  = cu_ready_ip;
            end
            default: ;
        endcase
        accept   = load_st && (sk_cnt != 2'd0) && rdy_cur;
        last_acc = accept && (acc_cnt == n_cur - 9'd1);
        // Count the in-flight read so the skid can never overflow when ready drops.
        occ         = sk_cnt + {1'b0, rd_pend} - {1'b0, accept};
        glb_rd_en   = load_st && (issued_cnt < n_cur) && (occ < 2'd2);
        glb_rd_addr = glb_rd_en ? base_cur + ADDR_W'(issued_cnt) : '0;
        cu_valid_w  = (state == LD_W)  && (sk_cnt != 2'd0);
        cu_valid_if = (state == LD_IF) && (sk_cnt != 2'd0);
        cu_valid_ip = (state == LD_IP) && (sk_cnt != 2'd0);
        cu_data_in  = (sk_cnt != 2'd0) ? sk0 : '0;
        cu_ready_op = (state == ST_OP) && (op_cnt < np);
        op_acc      = cu_ready_op && cu_valid_op;
        last_op     = op_acc && (op_cnt == np - 9'd1);
        glb_wr_en   = op_acc;
        glb_wr_addr = op_acc ? op_addr_q + ADDR_W'(op_cnt) : '0;
        glb_wr_data = op_acc ? cu_data_out : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            cu_change_weight_f <= 1'b0;
            row_q              <= '0;
            col_q              <= '0;
            npass_q            <= '0;
            pass_q             <= '0;
            w_base_q           <= '0;
            if_addr_q          <= '0;
            ip_addr_q          <= '0;
            op_addr_q          <= '0;
            issued_cnt         <= '0;
            acc_cnt            <= '0;
            op_cnt             <= '0;
            rd_pend            <= 1'b0;
            sk_cnt             <= '0;
            sk0                <= '0;
            sk1                <= '0;
        end else begin
            done               <= 1'b0;
            cu_change_weight_f <= 1'b0;
            rd_pend            <= glb_rd_en;

            case ({rd_pend, accept})
                2'b10: begin
                    if (sk_cnt == 2'd0) sk0 <= glb_rd_data;
                    else                sk1 <= glb_rd_data;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk0    <= sk1;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd2) begin
                        sk0 <= sk1;
                        sk1 <= glb_rd_data;
                    end else begin
                        sk0 <= glb_rd_data;
                    end
                end
                default: ;
            endcase

            if (glb_rd_en) issued_cnt <= issued_cnt + 9'd1;
            if (accept)    acc_cnt    <= acc_cnt + 9'd1;
            if (op_acc)    op_cnt     <= op_cnt + 9'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        row_q      <= cfg_row_en;
                        col_q      <= cfg_col_en;
                        npass_q    <= cfg_num_pass;
                        pass_q     <= '0;
                        w_base_q   <= cfg_w_base;
                        if_addr_q  <= cfg_if_base;
                        ip_addr_q  <= cfg_ip_base;
                        op_addr_q  <= cfg_op_base;
                        issued_cnt <= '0;
                        acc_cnt    <= '0;
                        op_cnt     <= '0;
                        if (cfg_row_en == '0 || cfg_col_en == '0 || cfg_num_pass == '0) begin
                            state <= FIN;
                        end else begin
                            state              <= LD_W;
                            cu_change_weight_f <= 1'b1;
                        end
                    end
                end
                LD_W, LD_IF, LD_IP: begin
                    if (last_acc) begin
                        issued_cnt <= '0;
                        acc_cnt    <= '0;
                        state      <= (state == LD_W) ? LD_IF : (state == LD_IF) ? LD_IP : ST_OP;
                    end
                end
                ST_OP: begin
                    if (last_op) begin
                        op_cnt    <= '0;
                        pass_q    <= pass_q + 1'b1;
                        if_addr_q <= if_addr_q + ADDR_W'(ni);
                        ip_addr_q <= ip_addr_q + ADDR_W'(np);
                        op_addr_q <= op_addr_q + ADDR_W'(np);
                        state     <= (pass_q == npass_q - 1'b1) ? FIN : LD_IF;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
